// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared entry type and sizing helper for the register-write hazard tracker
package hazard_pkg;

    localparam int ADDR_W_DEF = 5;
    // Entries hold addresses at the widest supported width; narrower ports are zero-extended.
    localparam int ADDR_W_MAX = 16;

    typedef struct packed {
        logic [ADDR_W_MAX-1:0] addr;
        logic                  valid;
        logic                  is_load;
    } hz_entry_t;

    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hazard_entry.sv
// rtl/hazard_entry.sv - one tracked pipeline stage register with hold and clear
module hazard_entry
    import hazard_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      en,
    input  logic      flush,
    input  hz_entry_t d,
    output hz_entry_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            if (flush) begin
                q <= '0;
            end else begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/hazard_tracker.sv
// rtl/hazard_tracker.sv - destination-register tracker producing hits, forwarding select and load-use stall
module hazard_tracker
    import hazard_pkg::*;
#(
    parameter  int ADDR_W      = ADDR_W_DEF,
    parameter  int DEPTH       = 2,
    parameter  int NPORTS      = 2,
    parameter  int LOAD_STAGES = 1,
    localparam int SEL_W       = sel_width(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      stalled,
    input  logic                      flush,
    input  logic [NPORTS*ADDR_W-1:0]  req_r,
    input  logic [ADDR_W-1:0]         req_w,
    input  logic                      req_w_load,
    output logic [NPORTS*DEPTH-1:0]   hit,
    output logic [NPORTS*SEL_W-1:0]   fwd_sel,
    output logic                      load_use
);

    hz_entry_t stage_d [DEPTH];
    hz_entry_t stage_q [DEPTH];

    // A stalled decode launches a bubble; a write to r0 is never a producer.
    always_comb begin
        stage_d[0] = '0;
        if (!stalled) begin
            stage_d[0].addr    = ADDR_W_MAX'(req_w);
            stage_d[0].valid   = (req_w != '0);
            stage_d[0].is_load = req_w_load && (req_w != '0);
        end
        for (int s = 1; s < DEPTH; s++) begin
            stage_d[s] = stage_q[s-1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        hazard_entry u_entry (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .flush (flush),
            .d     (stage_d[g]),
            .q     (stage_q[g])
        );
    end

    logic [ADDR_W_MAX-1:0] rd_addr;
    logic                  found;

    // Stage 0 is the youngest producer, so the first match scanning upward wins.
    always_comb begin
        hit      = '0;
        fwd_sel  = '0;
        load_use = 1'b0;
        rd_addr  = '0;
        found    = 1'b0;
        for (int p = 0; p < NPORTS; p++) begin
            rd_addr = ADDR_W_MAX'(req_r[p*ADDR_W +: ADDR_W]);
            found   = 1'b0;
            for (int s = 0; s < DEPTH; s++) begin
                if (stage_q[s].valid && (stage_q[s].addr == rd_addr)) begin
                    hit[p*DEPTH + s] = 1'b1;
                    if (!found) begin
                        fwd_sel[p*SEL_W +: SEL_W] = SEL_W'(s + 1);
                        found = 1'b1;
                    end
                    if ((s < LOAD_STAGES) && stage_q[s].is_load) begin
                        load_use = 1'b1;
                    end
                end
            end
        end
    end

endmodule
